// File: rtl/conv3x3_channel_engine.sv
// 3x3 window x NUM_OC kernel MAC pipeline with shift/saturate requantisation.
// Optional CONV_RELU_EN clamps negative shifted sums to zero.
module conv3x3_channel_engine #(
   parameter int NUM_OC = 8,
   parameter int SHIFT  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic signed [7:0] p0,
   input  logic signed [7:0] p1,
   input  logic signed [7:0] p2,
   input  logic signed [7:0] p3,
   input  logic signed [7:0] p4,
   input  logic signed [7:0] p5,
   input  logic signed [7:0] p6,
   input  logic signed [7:0] p7,
   input  logic signed [7:0] p8,
   output logic        [3:0] kern_addr,
   input  logic signed [7:0] k0,
   input  logic signed [7:0] k1,
   input  logic signed [7:0] k2,
   input  logic signed [7:0] k3,
   input  logic signed [7:0] k4,
   input  logic signed [7:0] k5,
   input  logic signed [7:0] k6,
   input  logic signed [7:0] k7,
   input  logic signed [7:0] k8,
   output logic              out_valid,
   input  logic              out_ready,
   output logic signed [7:0] out_data,
   output logic        [3:0] out_chan,
   output logic              out_last
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam logic [3:0] LAST = 4'(NUM_OC - 1);

   state_t             state, state_nx;
   logic        [3:0]  oc, s1_oc, s2_oc;
   logic               stall, accept, issue, s1_v, s2_v;
   logic signed [7:0]  pin [9];
   logic signed [7:0]  kin [9];
   logic signed [7:0]  pw [9];
   logic signed [15:0] s1_prod [9];
   logic signed [19:0] sum, s2_sum, shd;
   logic signed [7:0]  res;

   assign pin    = '{p0, p1, p2, p3, p4, p5, p6, p7, p8};
   assign kin    = '{k0, k1, k2, k3, k4, k5, k6, k7, k8};
   assign stall  = out_valid & ~out_ready;
   assign accept = in_valid & in_ready;
   assign issue  = (state == RUN) & ~stall;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept) state_nx = RUN;
         RUN:  if (issue && oc == LAST && !accept) state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      kern_addr = '0;
      unique case (state)
         IDLE: in_ready = 1'b1;
         RUN: begin
            in_ready  = ~stall & (oc == LAST);
            kern_addr = oc;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)      oc <= '0;
      else if (accept) oc <= '0;
      else if (issue)  oc <= (oc == LAST) ? 4'd0 : oc + 4'd1;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < 9; i++) pw[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < 9; i++) pw[i] <= pin[i];
      end

   // Any stall freezes the whole pipeline so results never reorder.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_v  <= 1'b0;
         s1_oc <= '0;
         for (int i = 0; i < 9; i++) s1_prod[i] <= '0;
      end else if (!stall) begin
         s1_v  <= (state == RUN);
         s1_oc <= oc;
         for (int i = 0; i < 9; i++)
            s1_prod[i] <= 16'(pw[i]) * 16'(kin[i]);
      end

   always_comb begin
      sum = '0;
      for (int i = 0; i < 9; i++) sum = sum + 20'(s1_prod[i]);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s2_v   <= 1'b0;
         s2_oc  <= '0;
         s2_sum <= '0;
      end else if (!stall) begin
         s2_v   <= s1_v;
         s2_oc  <= s1_oc;
         s2_sum <= sum;
      end

   always_comb begin
      shd = s2_sum >>> SHIFT;
`ifdef CONV_RELU_EN
      if (shd < 0) shd = '0;
`endif
      if (shd > 20'sd127)       res = 8'sd127;
      else if (shd < -20'sd128) res = -8'sd128;
      else                      res = shd[7:0];
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         out_last  <= 1'b0;
      end else if (!stall) begin
         out_valid <= s2_v;
         out_data  <= res;
         out_chan  <= s2_oc;
         out_last  <= (s2_oc == LAST);
      end
endmodule

// File: tb/tb_conv3x3_channel_engine.sv
// Randomised bench for conv3x3_channel_engine against an arithmetic model.
// Honours CONV_RELU_EN in the model.
module tb_conv3x3_channel_engine;
   localparam int NOC = 8;
   localparam int SH  = 6;

   logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
   logic in_ready, out_valid, out_last;
   logic        [3:0] kern_addr, out_chan;
   logic signed [7:0] out_data;
   logic signed [7:0] pix [9];
   logic signed [7:0] rom [16][9];

   int cyc = 0, n_cmp = 0, n_bad = 0;
   typedef struct {int d; int c; int l; int cy;} res_t;
   res_t exp_q[$];
   res_t got_q[$];
   int   acc_q[$];

   conv3x3_channel_engine #(.NUM_OC(NOC), .SHIFT(SH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .p0(pix[0]), .p1(pix[1]), .p2(pix[2]), .p3(pix[3]), .p4(pix[4]),
      .p5(pix[5]), .p6(pix[6]), .p7(pix[7]), .p8(pix[8]),
      .kern_addr(kern_addr),
      .k0(rom[kern_addr][0]), .k1(rom[kern_addr][1]), .k2(rom[kern_addr][2]),
      .k3(rom[kern_addr][3]), .k4(rom[kern_addr][4]), .k5(rom[kern_addr][5]),
      .k6(rom[kern_addr][6]), .k7(rom[kern_addr][7]), .k8(rom[kern_addr][8]),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_chan(out_chan), .out_last(out_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Dot product, floor-divide by 2^SH, optional ReLU, clamp to int8.
   function automatic int model(int ch);
      int  s = 0;
      real q;
      for (int i = 0; i < 9; i++) s += int'(pix[i]) * int'(rom[ch][i]);
      q = $floor(real'(s) / (2.0 ** SH));
      s = int'(q);
`ifdef CONV_RELU_EN
      if (s < 0) s = 0;
`endif
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return s;
   endfunction

   always @(negedge clk) if (rst_n) begin
      if (in_valid && in_ready) begin
         acc_q.push_back(cyc);
         for (int c = 0; c < NOC; c++)
            exp_q.push_back('{model(c), c, int'(c == NOC - 1), 0});
      end
      if (out_valid && out_ready)
         got_q.push_back('{int'(out_data), int'(out_chan), int'(out_last), cyc});
   end

   task automatic clear_q();
      exp_q.delete(); got_q.delete(); acc_q.delete();
   endtask

   task automatic rom_const(int v);
      for (int c = 0; c < 16; c++)
         for (int i = 0; i < 9; i++) rom[c][i] = 8'(v);
   endtask

   task automatic rom_rand();
      for (int c = 0; c < 16; c++)
         for (int i = 0; i < 9; i++) rom[c][i] = 8'($urandom);
   endtask

   task automatic pix_rand();
      for (int i = 0; i < 9; i++) pix[i] = 8'($urandom);
   endtask

   task automatic send();
      in_valid = 1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic wait_got(int n, int budget);
      for (int i = 0; i < budget && got_q.size() < n; i++) @(posedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 0 || kern_addr !== 0) begin
         n_bad++;
         $display("FAIL reset_ctl: out_valid=%b kern_addr=%0d, need 0 0", out_valid, kern_addr);
      end
      n_cmp++;
      if (out_data !== 0 || out_chan !== 0 || out_last !== 0) begin
         n_bad++;
         $display("FAIL reset_out: d=%0d c=%0d l=%b, need 0 0 0", out_data, out_chan, out_last);
      end
      rst_n = 1;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1) begin
         n_bad++;
         $display("FAIL reset_ready: in_ready=%b, need 1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      clear_q();
      rom_const(4);
      for (int i = 0; i < 9; i++) pix[i] = 8'sd16;
      send();
      wait_got(NOC, 60);
      n_cmp++;
      if (got_q.size() !== NOC) begin
         n_bad++;
         $display("FAIL basic_count: got %0d, need %0d", got_q.size(), NOC);
      end
      for (int i = 0; i < got_q.size() && i < NOC; i++) begin
         n_cmp++;
         if (got_q[i].d !== 9 || got_q[i].c !== i || got_q[i].l !== int'(i == NOC - 1)
             || got_q[i].d !== exp_q[i].d) begin
            n_bad++;
            $display("FAIL basic_ch%0d: got d=%0d c=%0d l=%0d, need d=9 c=%0d l=%0d",
                     i, got_q[i].d, got_q[i].c, got_q[i].l, i, int'(i == NOC - 1));
         end
      end
      if (got_q.size() > 0 && acc_q.size() > 0) begin
         n_cmp++;
         if (got_q[0].cy - acc_q[0] !== 4) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d, need 4", got_q[0].cy - acc_q[0]);
         end
      end
   endtask

   task automatic test_saturation();
      int need;
      for (int pass = 0; pass < 2; pass++) begin
         clear_q();
         rom_const(pass == 0 ? 127 : -128);
         for (int i = 0; i < 9; i++) pix[i] = 8'sd127;
`ifdef CONV_RELU_EN
         need = (pass == 0) ? 127 : 0;
`else
         need = (pass == 0) ? 127 : -128;
`endif
         send();
         wait_got(NOC, 60);
         n_cmp++;
         if (got_q.size() !== NOC) begin
            n_bad++;
            $display("FAIL sat%0d_count: got %0d, need %0d", pass, got_q.size(), NOC);
         end
         for (int i = 0; i < got_q.size() && i < NOC; i++) begin
            n_cmp++;
            if (got_q[i].d !== need || got_q[i].d !== exp_q[i].d || got_q[i].c !== i) begin
               n_bad++;
               $display("FAIL sat%0d_ch%0d: got d=%0d c=%0d, need d=%0d c=%0d",
                        pass, i, got_q[i].d, got_q[i].c, need, i);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic signed [7:0] hd;
      logic [3:0] hc;
      clear_q();
      rom_rand();
      pix_rand();
      send();
      for (int i = 0; i < 40 && !(out_valid && out_chan == 2); i++) begin
         @(posedge clk); #1;
      end
      out_ready = 0;
      hd = out_data;
      hc = out_chan;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (out_data !== hd || out_chan !== hc || out_valid !== 1 || hc !== 2) begin
            n_bad++;
            $display("FAIL stall_hold%0d: got d=%0d c=%0d v=%b, need d=%0d c=2 v=1",
                     k, out_data, out_chan, out_valid, hd);
         end
      end
      out_ready = 1;
      wait_got(NOC, 60);
      n_cmp++;
      if (got_q.size() !== NOC) begin
         n_bad++;
         $display("FAIL stall_count: got %0d, need %0d", got_q.size(), NOC);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i].d !== exp_q[i].d || got_q[i].c !== exp_q[i].c || got_q[i].l !== exp_q[i].l) begin
            n_bad++;
            $display("FAIL stall_res%0d: got d=%0d c=%0d l=%0d, need d=%0d c=%0d l=%0d", i,
                     got_q[i].d, got_q[i].c, got_q[i].l, exp_q[i].d, exp_q[i].c, exp_q[i].l);
         end
      end
   endtask

   task automatic test_back_to_back();
      int readies = 0;
      clear_q();
      rom_rand();
      pix_rand();
      in_valid = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      @(posedge clk); #1;
      pix_rand();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) readies++;
         if (in_ready) break;
      end
      @(posedge clk); #1;
      in_valid = 0;
      wait_got(2 * NOC, 80);
      n_cmp++;
      if (acc_q.size() !== 2 || readies !== 1 || acc_q[1] - acc_q[0] !== NOC) begin
         n_bad++;
         $display("FAIL b2b_accept: accepts=%0d gap=%0d readies=%0d, need 2 %0d 1",
                  acc_q.size(), acc_q.size() > 1 ? acc_q[1] - acc_q[0] : -1, readies, NOC);
      end
      n_cmp++;
      if (got_q.size() !== 2 * NOC) begin
         n_bad++;
         $display("FAIL b2b_count: got %0d, need %0d", got_q.size(), 2 * NOC);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i].d !== exp_q[i].d || got_q[i].c !== exp_q[i].c
             || got_q[i].l !== exp_q[i].l || got_q[i].cy !== got_q[0].cy + i) begin
            n_bad++;
            $display("FAIL b2b_res%0d: got d=%0d c=%0d cy+%0d, need d=%0d c=%0d cy+%0d", i,
                     got_q[i].d, got_q[i].c, got_q[i].cy - got_q[0].cy, exp_q[i].d, exp_q[i].c, i);
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_q();
      rom_rand();
      pix_rand();
      send();
      for (int i = 0; i < 20 && kern_addr != 3; i++) begin
         @(posedge clk); #1;
      end
      n_cmp++;
      if (kern_addr !== 3) begin
         n_bad++;
         $display("FAIL rstmid_oc: kern_addr=%0d, need 3", kern_addr);
      end
      rst_n = 0;
      #1;
      n_cmp++;
      if (out_valid !== 0 || kern_addr !== 0) begin
         n_bad++;
         $display("FAIL rstmid_flush: out_valid=%b kern_addr=%0d, need 0 0", out_valid, kern_addr);
      end
      @(posedge clk); #1;
      rst_n = 1;
      clear_q();
      @(posedge clk); #1;
      pix_rand();
      send();
      wait_got(NOC, 60);
      n_cmp++;
      if (got_q.size() !== NOC) begin
         n_bad++;
         $display("FAIL rstmid_count: got %0d, need %0d", got_q.size(), NOC);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i].d !== exp_q[i].d || got_q[i].c !== exp_q[i].c || got_q[i].l !== exp_q[i].l) begin
            n_bad++;
            $display("FAIL rstmid_res%0d: got d=%0d c=%0d, need d=%0d c=%0d", i,
                     got_q[i].d, got_q[i].c, exp_q[i].d, exp_q[i].c);
         end
      end
   endtask

   task automatic test_random();
      clear_q();
      rom_rand();
      fork
         for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
         end
         for (int w = 0; w < 6; w++) begin
            pix_rand();
            send();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
      join
      out_ready = 1;
      wait_got(6 * NOC, 300);
      n_cmp++;
      if (got_q.size() !== 6 * NOC || exp_q.size() !== 6 * NOC) begin
         n_bad++;
         $display("FAIL rand_count: got %0d exp %0d, need %0d", got_q.size(), exp_q.size(), 6 * NOC);
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (got_q[i].d !== exp_q[i].d || got_q[i].c !== exp_q[i].c || got_q[i].l !== exp_q[i].l) begin
            n_bad++;
            $display("FAIL rand_res%0d: got d=%0d c=%0d l=%0d, need d=%0d c=%0d l=%0d", i,
                     got_q[i].d, got_q[i].c, got_q[i].l, exp_q[i].d, exp_q[i].c, exp_q[i].l);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 9; i++) pix[i] = 0;
      rom_const(0);
      test_reset();
      test_basic();
      test_saturation();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/conv3x3_channel_engine.md
CONV3X3_CHANNEL_ENGINE -- requirements
Module: conv3x3_channel_engine

Interface
REQ-001 The block SHALL have parameter NUM_OC, default 8, giving the number of output channels (kernels) per window, range 1..16.
REQ-002 The block SHALL have parameter SHIFT, default 6, giving the requantisation arithmetic right-shift, range 0..12.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  window present on p0..p8.
REQ-007 in_ready  output  1  block accepts a window this cycle.
REQ-008 p0..p8  input  8 each, signed  3x3 pixel window, row-major.
REQ-009 kern_addr  output  4  kernel index driven to the weight ROM.
REQ-010 k0..k8  input  8 each, signed  weights returned combinationally for kern_addr.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_data  output  8, signed  requantised result.
REQ-014 out_chan  output  4  channel index of out_data.
REQ-015 out_last  output  1  out_chan equals NUM_OC-1.

Function
REQ-016 The FSM SHALL have two states: IDLE and RUN.
REQ-017 Accept SHALL occur when in_valid and in_ready are both high; p0..p8 SHALL be registered on accept, and the FSM SHALL enter RUN with channel counter oc=0.
REQ-018 in_ready SHALL be high in IDLE, and in RUN only when oc==NUM_OC-1 and the pipeline is not stalled; this gives back-to-back windows with no bubble.
REQ-019 kern_addr SHALL equal oc in RUN and 0 in IDLE.
REQ-020 In RUN and not stalled, each cycle SHALL register the nine products pN*kN (16-bit signed) in stage 1, tagged with oc, then increment oc.
REQ-021 After issuing oc==NUM_OC-1, the FSM SHALL go to IDLE, or SHALL reload oc=0 and stay in RUN if a new window is accepted in the same cycle.
REQ-022 Stage 2 SHALL register the 20-bit signed sum of the nine products; the sign-extended sum SHALL never overflow.
REQ-023 Stage 3 SHALL register out_data as the sum arithmetically shifted right by SHIFT, saturated to [-128,127], together with out_chan and out_last.
REQ-024 Latency SHALL be fixed: with a window accepted in cycle T and no stall, out_valid for channel 0 SHALL rise in cycle T+4, and channels 1..NUM_OC-1 SHALL follow on consecutive cycles.
REQ-025 A stall SHALL be out_valid high with out_ready low; during a stall, oc, the FSM state, all stage registers and all outputs SHALL hold, and no result SHALL be lost or duplicated.
REQ-026 Each pipeline stage SHALL carry a valid bit, and out_valid SHALL be the stage-3 valid bit.
REQ-027 A result SHALL be consumed when out_valid and out_ready are both high.

Reset
REQ-028 While rst_n is low, the FSM SHALL be IDLE, and oc, all valid bits, kern_addr, out_data, out_chan and out_last SHALL be 0.
REQ-029 Assertion of rst_n mid-RUN SHALL discard the in-flight window and all pipeline contents.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-031 When CONV_RELU_EN is defined, stage 3 SHALL clamp negative shifted sums to 0 before saturation, so out_data lies in [0,127].
REQ-032 When CONV_RELU_EN is undefined, stage 3 SHALL saturate signed values to [-128,127] with no clamp.

Verification
REQ-033 p=16 everywhere, ROM channel c weights all 4 -> out_data=9 (576>>>6) for all 8 channels, out_chan 0..7, out_last only on channel 7, first out_valid at T+4.
REQ-034 p=127 and weights all 127 -> sum 145161 -> out_data=127 (saturated).
REQ-035 p=127 and weights all -128 -> out_data=-128; with CONV_RELU_EN defined, out_data=0.
REQ-036 out_ready held low for 3 cycles while out_chan=2 -> out_data and out_chan stable, then channels 2..7 are delivered exactly once each.
REQ-037 in_valid held high with 2 distinct windows -> 16 results on 16 consecutive cycles, and in_ready pulses only on oc==7.
REQ-038 rst_n asserted while oc=3 -> out_valid=0 immediately, then a fresh window after reset yields correct channels 0..7.
